pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline control unit for the CPU core. It replaces the fixed, always-idle stall controller. It turns per-stage stall and flush requests into per-register hold/kill controls and tracks a valid bit for every stage. It also runs a boot/run/hang state machine with a stall watchdog. It sits beside the stage modules in the core top and drives the stall bus that every stage consumes.

## Interface

Parameters:

- STAGES, 5: number of pipeline stages. Stage 0 is fetch; stage STAGES-1 is writeback. Register i feeds stage i, and register 0 is the PC.
- HANG_LIMIT, 1024: consecutive PC-hold cycles in RUN that trip the watchdog. Must be ≥2.
- CNT_W, 32: performance counter width.

Ports:

- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-low.
- stallreq  in  STAGES  bit i set: stage i cannot advance this cycle.
- flushreq  in  STAGES  bit i set: stage i kills all younger stages (0..i-1) and redirects the PC.
- hold  out  STAGES  bit i set: register i keeps its value.
- kill  out  STAGES  bit i set: register i loads a bubble. Bit 0 is always 0.
- valid  out  STAGES  stage i holds a live instruction (registered).
- hang  out  1  watchdog tripped (registered, sticky).
- stall_cycles, flush_count, retired  out  CNT_W each  performance counters (see Configuration).

## Operation

Per-cycle combinational resolution:

- Live requests: sreq = stallreq & valid and freq = flushreq & valid.
- h is the highest index set in sreq (none if sreq = 0). f is the highest index set in freq (none if freq = 0).
- **Flush case** (f exists, and either h does not exist or f > h):
  - hold = 0.
  - kill[j] = 1 for 1 ≤ j ≤ f.
  - The PC loads the redirect target, which the requester supplies directly to the fetch stage.
- **Stall case** (h exists, and either f does not exist or h ≥ f):
  - hold[j] = 1 for j ≤ h.
  - kill[h+1] = 1 if h+1 < STAGES.
  - The flush is deferred; the requester keeps flushreq high until accepted.
- **Neither**: hold = 0 and kill = 0.

State machine (valid advances only in RUN):

- BOOT (reset state): hold = all 1, kill = 0, valid = 0. Moves to RUN on the first clock after rst deasserts.
- RUN: normal resolution as above. Moves to HANG when the hold[0] run-length counter reaches HANG_LIMIT.
- HANG: hold = all 1, kill = 0, hang = 1. Leaves only through reset.

Valid update in RUN, in priority order:

1. Register j with kill[j] = 1: valid[j] ← 0.
2. Otherwise, register j with hold[j] = 1: valid[j] keeps its value.
3. Otherwise: valid[j] ← valid[j-1], and valid[0] ← 1.

Watchdog:

- The run-length counter increments on every RUN cycle with hold[0] = 1.
- It clears on any cycle with hold[0] = 0.
- It saturates at HANG_LIMIT.

## Timing

- stallreq and flushreq reach hold and kill in the same cycle, through a purely combinational path. There are no combinational paths from the inputs to valid or hang.
- Reset values: state = BOOT, valid = 0, hang = 0, watchdog counter = 0, all counters = 0.
  - hold = all 1 and kill = 0 while rst is low, and during the first BOOT cycle after rst goes high.
- Reset asserted mid-stall or mid-flush clears all state immediately (asynchronous); no pending request is remembered.
- Flush and stall on the same stage (f = h): the stall wins. Stage f stays held, and the flush is taken on the first cycle its stall drops.
- A stall on a stage that is not valid is ignored. A flush from a stage that is not valid is ignored.
- retired increments when valid[STAGES-1] = 1 and hold[STAGES-1] = 0.

## Configuration

PIPE_CTRL_PERF_EN:

- **Defined**:
  - stall_cycles counts RUN cycles with hold[0] = 1.
  - flush_count counts cycles in which the flush case is taken.
  - retired counts as defined in Timing.
  - All three wrap modulo 2^CNT_W.
- **Undefined**: all three outputs are tied to 0 and no counter flops are built. All other behaviour is identical.

## Structure

- Shared package: the state encoding (BOOT = 2'd0, RUN = 2'd1, HANG = 2'd2) and the default STAGES and HANG_LIMIT constants, placed alongside the existing bus-width defines.
- One sub-module, pipe_prio_enc, returns the highest set bit index plus a found flag. It is instantiated twice, once for h and once for f.

## Test plan

All scenarios use STAGES = 5.

1. Reset then release, with no requests:
   - hold = 5'b11111 during reset and the BOOT cycle.
   - valid fills as 00001, 00011, … up to 11111 by RUN cycle 5.
   - retired increments from cycle 5 onward.
2. stallreq = 5'b00100 for 3 cycles with full valid:
   - hold = 00111 and kill = 01000 on each of those cycles.
   - valid[3] = 0 for 3 cycles afterward.
   - stall_cycles = 3.
3. flushreq = 5'b00010 for 1 cycle:
   - hold = 0, kill = 00010, valid[1] ← 0.
   - flush_count = 1.
4. stallreq = 5'b01000 together with flushreq = 5'b00100:
   - Stall case: hold = 01111, kill = 10000.
   - When stallreq drops, the flush case is taken: kill = 00110.
5. stallreq = 5'b00001 held continuously with HANG_LIMIT = 8:
   - hang = 1 after the 8th hold cycle and stays 1.
   - Asserting rst low clears hang and returns to BOOT.
6. stallreq = 5'b11111 with valid = 0 (first BOOT/RUN cycles): no hold from the requests.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and defaults: FSM state encoding, stage/watchdog
// defaults and the index-width helper used by the priority encoders.
package pipe_ctrl_pkg;

  localparam int unsigned BUS_W          = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned STAGES_DEF     = 5;
  localparam int unsigned HANG_LIMIT_DEF = 1024;
  localparam int unsigned CNT_W_DEF      = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HANG = 2'd2
  } state_e;

  // Width of an index into an n-entry vector (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_prio_enc.sv
// Highest-set-bit priority encoder: returns the top requesting index and a found flag.
module pipe_prio_enc
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = STAGES_DEF
) (
  input  logic [W-1:0]        req_i,
  output logic [idx_w(W)-1:0] idx_c_o,
  output logic                found_c_o
);

  localparam int unsigned IDX_W = idx_w(W);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx_c_o   = '0;
    found_c_o = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (req_i[i]) begin
        idx_c_o   = IDX_W'(i);
        found_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: resolves stall/flush requests into hold/kill, tracks stage
// valid bits, runs a BOOT/RUN/HANG FSM with a PC-hold watchdog.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES     = STAGES_DEF,
  parameter int unsigned HANG_LIMIT = HANG_LIMIT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic [STAGES-1:0] flushreq,
  output logic [STAGES-1:0] hold,
  output logic [STAGES-1:0] kill,
  output logic [STAGES-1:0] valid,
  output logic              hang,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned IDX_W = idx_w(STAGES);
  localparam int unsigned WD_W  = $clog2(HANG_LIMIT + 1);

  state_e              state_q, state_d;
  logic [STAGES-1:0]   valid_q, valid_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                hang_q, hang_d;

  logic [STAGES-1:0]   sreq, freq, valid_shift;
  logic [IDX_W-1:0]    h_idx, f_idx;
  logic                h_found, f_found;
  logic                flush_case, stall_case, flush_taken;

  assign sreq        = stallreq & valid_q;
  assign freq        = flushreq & valid_q;
  assign valid_shift = {valid_q[STAGES-2:0], 1'b1};

  pipe_prio_enc #(.W(STAGES)) u_stall_enc (
    .req_i     (sreq),
    .idx_c_o   (h_idx),
    .found_c_o (h_found)
  );

  pipe_prio_enc #(.W(STAGES)) u_flush_enc (
    .req_i     (freq),
    .idx_c_o   (f_idx),
    .found_c_o (f_found)
  );

  // Equal indices resolve as a stall; the flush waits until the stall drops.
  assign flush_case = f_found && (!h_found || (f_idx > h_idx));
  assign stall_case = h_found && !flush_case;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      valid_q <= '0;
      wd_q    <= '0;
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      wd_q    <= wd_d;
      hang_q  <= hang_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold        = '1;
    kill        = '0;
    valid_d     = valid_q;
    wd_d        = wd_q;
    flush_taken = 1'b0;

    if (state_q == ST_RUN) begin
      hold = '0;
      for (int j = 0; j < int'(STAGES); j++) begin
        if (flush_case && (j >= 1) && (32'(j) <= 32'(f_idx))) kill[j] = 1'b1;
        if (stall_case && (32'(j) <= 32'(h_idx))) hold[j] = 1'b1;
        if (stall_case && (32'(j) == 32'(h_idx) + 32'd1)) kill[j] = 1'b1;
      end
      flush_taken = flush_case;
      for (int j = 0; j < int'(STAGES); j++) begin
        if (kill[j])       valid_d[j] = 1'b0;
        else if (!hold[j]) valid_d[j] = valid_shift[j];
      end
    end

    // Run-length of PC holds; only RUN can drop hold[0].
    if (!hold[0]) begin
      wd_d = '0;
    end else if ((state_q == ST_RUN) && (wd_q != WD_W'(HANG_LIMIT))) begin
      wd_d = wd_q + WD_W'(1);
    end

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (wd_d == WD_W'(HANG_LIMIT)) state_d = ST_HANG;
      ST_HANG: state_d = ST_HANG;
      default: state_d = ST_BOOT;
    endcase

    hang_d = hang_q | (state_d == ST_HANG);
  end

  assign valid = valid_q;
  assign hang  = hang_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q, retired_q;
  logic             run_c;

  assign run_c = (state_q == ST_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      retired_q      <= '0;
    end else begin
      if (run_c && hold[0]) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (flush_taken)      flush_count_q  <= flush_count_q + CNT_W'(1);
      if (valid_q[STAGES-1] && !hold[STAGES-1]) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
  assign retired      = retired_q;
`else
  logic unused_flush;
  assign unused_flush = flush_taken;
  assign stall_cycles = '0;
  assign flush_count  = '0;
  assign retired      = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (STAGES=5, HANG_LIMIT=8) with hand-computed expectations.
module tb_pipe_ctrl;

  localparam int unsigned STAGES = 5;
  localparam int unsigned CNT_W  = 32;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [STAGES-1:0] stallreq;
  logic [STAGES-1:0] flushreq;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] valid;
  logic              hang;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;
  logic [CNT_W-1:0]  retired;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.STAGES(STAGES), .HANG_LIMIT(8), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq     (stallreq),
    .flushreq     (flushreq),
    .hold         (hold),
    .kill         (kill),
    .valid        (valid),
    .hang         (hang),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pexp(input int v);
    return PERF ? 64'(v) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag, input int sc, input int fc, input int rt);
    check_eq({tag, ".stall_cycles"}, 64'(stall_cycles), pexp(sc));
    check_eq({tag, ".flush_count"},  64'(flush_count),  pexp(fc));
    check_eq({tag, ".retired"},      64'(retired),      pexp(rt));
  endtask

  initial begin
    rst      = 1'b0;
    stallreq = '0;
    flushreq = '0;
    #3;
    check_eq("rst.hold",  64'(hold),  64'h1f);
    check_eq("rst.kill",  64'(kill),  64'h0);
    check_eq("rst.valid", 64'(valid), 64'h0);
    check_eq("rst.hang",  64'(hang),  64'h0);
    check_perf("rst", 0, 0, 0);

    // Release; BOOT cycle holds everything, requests on invalid stages are ignored.
    #9;
    rst      = 1'b1;
    stallreq = 5'b11111;
    #1;
    check_eq("boot.hold", 64'(hold), 64'h1f);
    check_eq("boot.kill", 64'(kill), 64'h0);
    tick();
    check_eq("run1.hold_invalid", 64'(hold), 64'h0);
    check_eq("run1.kill_invalid", 64'(kill), 64'h0);
    check_eq("run1.valid",        64'(valid), 64'h0);
    stallreq = '0;

    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq($sformatf("fill%0d.valid", k), 64'(valid), 64'((1 << k) - 1));
    end
    check_perf("fill5", 0, 0, 0);
    tick();
    check_perf("fill6", 0, 0, 1);

    // Stall on stage 2 for three cycles.
    stallreq = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("stall%0d.hold", i), 64'(hold), 64'h07);
      check_eq($sformatf("stall%0d.kill", i), 64'(kill), 64'h08);
      tick();
    end
    stallreq = '0;
    check_eq("stall_end.valid", 64'(valid), 64'h07);
    check_perf("stall_end", 3, 0, 3);
    tick();
    check_eq("stall_post1.valid", 64'(valid), 64'h0f);
    tick();
    check_eq("stall_post2.valid", 64'(valid), 64'h1f);

    // Single-cycle flush from stage 1.
    flushreq = 5'b00010;
    #1;
    check_eq("flush.hold", 64'(hold), 64'h0);
    check_eq("flush.kill", 64'(kill), 64'h02);
    tick();
    flushreq = '0;
    check_eq("flush_post.valid", 64'(valid), 64'h1d);
    check_perf("flush_post", 3, 1, 4);

    // Stall on 3 defers a flush from 2; flush taken once the stall drops.
    stallreq = 5'b01000;
    flushreq = 5'b00100;
    #1;
    check_eq("sf.hold", 64'(hold), 64'h0f);
    check_eq("sf.kill", 64'(kill), 64'h10);
    tick();
    stallreq = '0;
    check_eq("sf.valid_held", 64'(valid), 64'h0d);
    #1;
    check_eq("sf_flush.hold", 64'(hold), 64'h0);
    check_eq("sf_flush.kill", 64'(kill), 64'h06);
    tick();
    flushreq = '0;
    check_eq("sf_post.valid", 64'(valid), 64'h19);
    check_perf("sf_post", 4, 2, 5);

    // Continuous PC stall trips the watchdog after 8 hold cycles.
    stallreq = 5'b00001;
    #1;
    check_eq("wd.hold", 64'(hold), 64'h01);
    check_eq("wd.kill", 64'(kill), 64'h02);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("wd%0d.hang", i), 64'(hang), 64'h0);
      tick();
    end
    check_eq("hang.hang", 64'(hang), 64'h1);
    check_eq("hang.hold", 64'(hold), 64'h1f);
    check_eq("hang.kill", 64'(kill), 64'h0);
    check_perf("hang", 12, 2, 7);
    for (int i = 0; i < 3; i++) tick();
    check_eq("hang_sticky.hang", 64'(hang), 64'h1);
    check_perf("hang_sticky", 12, 2, 7);

    // Asynchronous reset while hung.
    rst = 1'b0;
    #1;
    check_eq("rst2.hang",  64'(hang),  64'h0);
    check_eq("rst2.valid", 64'(valid), 64'h0);
    check_eq("rst2.hold",  64'(hold),  64'h1f);
    check_eq("rst2.kill",  64'(kill),  64'h0);
    check_perf("rst2", 0, 0, 0);
    #4;
    rst = 1'b1;
    #1;
    check_eq("boot2.hold", 64'(hold), 64'h1f);
    tick();
    check_eq("run2.hold", 64'(hold), 64'h0);
    check_eq("run2.hang", 64'(hang), 64'h0);
    stallreq = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
